// File: rtl/kmeans_stream_cluster.sv
// Streaming K-means greyscale segmenter: ACCUM passes, serial divide per cluster, final LABEL pass.
// LABEL output is one cycle after input handshake; a stalled output holds data and drops s_ready.
module kmeans_stream_cluster #(
   parameter int DATA_W = 8,
   parameter int K      = 4,
   parameter int NPIX   = 900,
   parameter int ITERS  = 4,
   parameter int LBL_W  = $clog2(K),
   parameter int IT_W   = $clog2(ITERS + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   input  logic [DATA_W-1:0] i_s_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [LBL_W-1:0]  o_m_label,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_pass_start,
   output logic [IT_W-1:0]   o_iter_count,
   output logic              o_busy,
   output logic              o_done
);
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam int SUM_W = DATA_W + CNT_W;
   localparam int ST_W  = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_LABEL, S_DONE} state_t;

   function automatic logic [DATA_W-1:0] f_init_cent(input int i);
      return DATA_W'((i * ((1 << DATA_W) - 1)) / (K - 1));
   endfunction

   state_t             r_state, w_next;
   logic [DATA_W-1:0]  r_cent [K];
   logic [SUM_W-1:0]   r_sum  [K];
   logic [CNT_W-1:0]   r_cnt  [K];
   logic [CNT_W-1:0]   r_pix_cnt, r_out_cnt;
   logic [IT_W-1:0]    r_iter;
   logic               r_change, r_pass_start, r_m_valid;
   logic [LBL_W-1:0]   r_m_label, r_cl;
   logic [DATA_W-1:0]  r_m_data, r_dvd;
   logic [CNT_W-1:0]   r_rem;
   logic [ST_W-1:0]    r_step;

   logic signed [DATA_W:0] w_sd   [K];
   logic [DATA_W:0]        w_dist [K];
   logic [DATA_W:0]        w_best;
   logic [LBL_W-1:0]       w_idx;
   logic                   w_in_hs, w_out_hs, w_pix_last;
   logic [CNT_W:0]         w_rem_sh;
   logic                   w_qbit, w_last_step, w_last_cl, w_upd, w_chg, w_div_end, w_stop;
   logic [CNT_W-1:0]       w_rem_nxt;
   logic [DATA_W-1:0]      w_quot;

   // Nearest centroid, shared by ACCUM and LABEL; strict < keeps the lowest index on ties.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         w_sd[i]   = $signed({1'b0, i_s_data}) - $signed({1'b0, r_cent[i]});
         w_dist[i] = w_sd[i][DATA_W] ? unsigned'(-w_sd[i]) : unsigned'(w_sd[i]);
      end
      w_idx  = '0;
      w_best = w_dist[0];
      for (int i = 1; i < K; i++) begin
         if (w_dist[i] < w_best) begin
            w_best = w_dist[i];
            w_idx  = LBL_W'(i);
         end
      end
   end

   assign o_s_ready  = (r_state == S_ACCUM) ||
                       ((r_state == S_LABEL) && (i_m_ready || !r_m_valid) && (r_pix_cnt != CNT_W'(NPIX)));
   assign w_in_hs    = i_s_valid && o_s_ready;
   assign w_out_hs   = r_m_valid && i_m_ready;
   assign w_pix_last = (r_pix_cnt == CNT_W'(NPIX - 1));

   // Restoring division: remainder stays below cnt, so the shifted value fits in CNT_W+1 bits.
   assign w_rem_sh    = {r_rem, r_dvd[DATA_W-1]};
   assign w_qbit      = (w_rem_sh >= {1'b0, r_cnt[r_cl]});
   assign w_rem_nxt   = w_qbit ? (w_rem_sh[CNT_W-1:0] - r_cnt[r_cl]) : w_rem_sh[CNT_W-1:0];
   assign w_quot      = {r_dvd[DATA_W-2:0], w_qbit};
   assign w_last_step = (r_step == ST_W'(DATA_W));
   assign w_last_cl   = (r_cl == LBL_W'(K - 1));
   assign w_upd       = (r_state == S_DIVIDE) && w_last_step && (r_cnt[r_cl] != '0);
   assign w_chg       = w_upd && (w_quot != r_cent[r_cl]);
   assign w_div_end   = (r_state == S_DIVIDE) && w_last_step && w_last_cl;
   assign w_stop      = !(r_change || w_chg) || ((r_iter + IT_W'(1)) == IT_W'(ITERS));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_busy = (r_state != S_IDLE);
      o_done = (r_state == S_DONE);
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_ACCUM;
         S_ACCUM:  if (w_in_hs && w_pix_last) w_next = S_DIVIDE;
         S_DIVIDE: if (w_div_end) w_next = w_stop ? S_LABEL : S_ACCUM;
         S_LABEL:  if (w_out_hs && (r_out_cnt == CNT_W'(NPIX - 1))) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < K; i++) begin
            r_cent[i] <= f_init_cent(i);
            r_sum[i]  <= '0;
            r_cnt[i]  <= '0;
         end
         r_pix_cnt    <= '0;
         r_out_cnt    <= '0;
         r_iter       <= '0;
         r_change     <= 1'b0;
         r_pass_start <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_label    <= '0;
         r_m_data     <= '0;
         r_cl         <= '0;
         r_dvd        <= '0;
         r_rem        <= '0;
         r_step       <= '0;
      end else begin
         r_pass_start <= (w_next != r_state) && ((w_next == S_ACCUM) || (w_next == S_LABEL));
         case (r_state)
            S_IDLE: if (i_start) begin
               for (int i = 0; i < K; i++) begin
                  r_cent[i] <= f_init_cent(i);
                  r_sum[i]  <= '0;
                  r_cnt[i]  <= '0;
               end
               r_iter    <= '0;
               r_change  <= 1'b0;
               r_pix_cnt <= '0;
               r_out_cnt <= '0;
            end
            S_ACCUM: if (w_in_hs) begin
               r_sum[w_idx] <= r_sum[w_idx] + SUM_W'(i_s_data);
               r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
               r_pix_cnt    <= w_pix_last ? '0 : r_pix_cnt + CNT_W'(1);
               if (w_pix_last) begin
                  r_cl   <= '0;
                  r_step <= '0;
               end
            end
            S_DIVIDE: begin
               if (r_step == '0) begin
                  r_rem  <= r_sum[r_cl][SUM_W-1:DATA_W];
                  r_dvd  <= r_sum[r_cl][DATA_W-1:0];
                  r_step <= ST_W'(1);
               end else begin
                  r_rem <= w_rem_nxt;
                  r_dvd <= w_quot;
                  if (w_last_step) begin
                     r_step <= '0;
                     r_cl   <= r_cl + LBL_W'(1);
                     if (w_upd) r_cent[r_cl] <= w_quot;
                     if (w_chg) r_change <= 1'b1;
                  end else begin
                     r_step <= r_step + ST_W'(1);
                  end
               end
               if (w_div_end) begin
                  r_iter   <= r_iter + IT_W'(1);
                  r_change <= 1'b0;
                  if (!w_stop) begin
                     for (int i = 0; i < K; i++) begin
                        r_sum[i] <= '0;
                        r_cnt[i] <= '0;
                     end
                  end
               end
            end
            S_LABEL: begin
               if (w_in_hs) begin
                  r_m_valid <= 1'b1;
                  r_m_label <= w_idx;
                  r_m_data  <= r_cent[w_idx];
                  r_pix_cnt <= r_pix_cnt + CNT_W'(1);
               end else if (i_m_ready) begin
                  r_m_valid <= 1'b0;
               end
               if (w_out_hs) r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_m_valid    = r_m_valid;
   assign o_m_label    = r_m_label;
   assign o_m_data     = r_m_data;
   assign o_pass_start = r_pass_start;
   assign o_iter_count = r_iter;
endmodule

// File: tb/tb_kmeans_stream_cluster.sv
// Randomised bench for kmeans_stream_cluster against a plain-arithmetic k-means reference.
module tb_kmeans_stream_cluster;
   localparam int DATA_W = 8;
   localparam int K      = 4;
   localparam int NPIX   = 8;
   localparam int ITERS  = 4;
   localparam int LBL_W  = 2;
   localparam int IT_W   = 3;

   logic              clk = 1'b0;
   logic              i_rst_n = 1'b1;
   logic              i_start = 1'b0;
   logic              i_s_valid = 1'b0;
   logic              o_s_ready;
   logic [DATA_W-1:0] i_s_data = '0;
   logic              o_m_valid;
   logic              i_m_ready = 1'b1;
   logic [LBL_W-1:0]  o_m_label;
   logic [DATA_W-1:0] o_m_data;
   logic              o_pass_start;
   logic [IT_W-1:0]   o_iter_count;
   logic              o_busy;
   logic              o_done;

   kmeans_stream_cluster #(.DATA_W(DATA_W), .K(K), .NPIX(NPIX), .ITERS(ITERS)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
      .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_label(o_m_label), .o_m_data(o_m_data),
      .o_pass_start(o_pass_start), .o_iter_count(o_iter_count), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int cur_frame [NPIX];
   int exp_lbl   [NPIX];
   int exp_dat   [NPIX];
   int exp_iters;
   bit exp_capped;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int absi(input int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic int nearest(input int px, input int c[K]);
      int best = 0;
      for (int k = 1; k < K; k++)
         if (absi(px - c[k]) < absi(px - c[best])) best = k;
      return best;
   endfunction

   function automatic void ref_model();
      int c[K];
      int s[K];
      int n[K];
      bit chg;
      for (int k = 0; k < K; k++) c[k] = (k * ((1 << DATA_W) - 1)) / (K - 1);
      exp_iters = 0;
      do begin
         for (int k = 0; k < K; k++) begin s[k] = 0; n[k] = 0; end
         for (int x = 0; x < NPIX; x++) begin
            s[nearest(cur_frame[x], c)] += cur_frame[x];
            n[nearest(cur_frame[x], c)] += 1;
         end
         chg = 1'b0;
         for (int k = 0; k < K; k++)
            if (n[k] != 0) begin
               if (s[k] / n[k] != c[k]) chg = 1'b1;
               c[k] = s[k] / n[k];
            end
         exp_iters++;
      end while (chg && exp_iters < ITERS);
      exp_capped = chg;
      for (int x = 0; x < NPIX; x++) begin
         exp_lbl[x] = nearest(cur_frame[x], c);
         exp_dat[x] = c[exp_lbl[x]];
      end
   endfunction

   // All tasks start and end at a falling edge, before inputs for that cycle are driven.
   task automatic wait_pass(output int ncyc);
      ncyc = 0;
      while (!o_pass_start && ncyc < 200) begin
         check_eq("div_srdy", int'(o_s_ready), 0);
         i_s_valid = 1'($urandom_range(1));
         i_s_data  = DATA_W'($urandom);
         @(negedge clk);
         ncyc++;
      end
      i_s_valid = 1'b0;
   endtask

   task automatic feed_accum(input int npx);
      int i = 0;
      int cyc = 0;
      while (i < npx && cyc < 1000) begin
         i_s_valid = ($urandom_range(3) != 0);
         i_s_data  = DATA_W'(cur_frame[i]);
         #1;
         check_eq("acc_srdy", int'(o_s_ready), 1);
         if (i_s_valid && o_s_ready) i++;
         @(negedge clk);
         cyc++;
      end
      i_s_valid = 1'b0;
      check_eq("acc_count", i, npx);
   endtask

   task automatic label_pass(input bit bp);
      int in_i = 0, out_i = 0, cyc = 0, word = 0, prev_word = 0;
      bit prev_stall = 1'b0, prev_in = 1'b0;
      while (out_i < NPIX && cyc < 2000) begin
         i_m_ready = bp ? 1'($urandom_range(1)) : 1'b1;
         if (in_i < NPIX) begin
            i_s_valid = bp ? 1'($urandom_range(1)) : 1'b1;
            i_s_data  = DATA_W'(cur_frame[in_i]);
         end else begin
            i_s_valid = 1'b0;
            i_s_data  = DATA_W'($urandom);
         end
         #1;
         word = int'({o_m_valid, o_m_label, o_m_data});
         if (prev_in) check_eq("lbl_latency", int'(o_m_valid), 1);
         if (prev_stall) check_eq("stall_hold", word, prev_word);
         if (o_m_valid && !i_m_ready) check_eq("stall_srdy", int'(o_s_ready), 0);
         prev_in    = i_s_valid && o_s_ready;
         prev_stall = o_m_valid && !i_m_ready;
         prev_word  = word;
         if (prev_in) in_i++;
         if (o_m_valid && i_m_ready) begin
            check_eq("label", int'(o_m_label), exp_lbl[out_i]);
            check_eq("cdata", int'(o_m_data), exp_dat[out_i]);
            out_i++;
         end
         @(negedge clk);
         cyc++;
      end
      i_s_valid = 1'b0;
      i_m_ready = 1'b1;
      check_eq("out_count", out_i, NPIX);
      check_eq("done_pulse", int'(o_done), 1);
      check_eq("done_busy", int'(o_busy), 1);
      check_eq("done_mvld", int'(o_m_valid), 0);
      @(negedge clk);
      check_eq("done_clear", int'(o_done), 0);
      check_eq("idle_busy", int'(o_busy), 0);
   endtask

   task automatic do_reset(input string tag);
      #2 i_rst_n = 1'b0;
      #1;
      check_eq({tag, "_srdy"}, int'(o_s_ready), 0);
      check_eq({tag, "_busy"}, int'(o_busy), 0);
      check_eq({tag, "_mvld"}, int'(o_m_valid), 0);
      check_eq({tag, "_pass"}, int'(o_pass_start), 0);
      check_eq({tag, "_iter"}, int'(o_iter_count), 0);
      i_s_valid = 1'b0;
      i_m_ready = 1'b1;
      @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);
   endtask

   // mode 0: full job; 1: reset after three ACCUM pixels; 2: reset with a stalled LABEL word.
   task automatic run_job(input int mode, input bit bp);
      int ncyc;
      ref_model();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int p = 0; p < exp_iters; p++) begin
         wait_pass(ncyc);
         check_eq(p == 0 ? "start_lat" : "div_len", ncyc, p == 0 ? 0 : K * (DATA_W + 1));
         check_eq("iter_accum", int'(o_iter_count), p);
         if (mode == 1) begin
            feed_accum(3);
            do_reset("rst_accum");
            return;
         end
         feed_accum(NPIX);
      end
      wait_pass(ncyc);
      check_eq("div_len", ncyc, K * (DATA_W + 1));
      check_eq("iter_label", int'(o_iter_count), exp_iters);
      if (mode == 2) begin
         i_m_ready = 1'b0;
         i_s_valid = 1'b1;
         i_s_data  = DATA_W'(cur_frame[0]);
         @(negedge clk);
         i_s_valid = 1'b0;
         #1 check_eq("pre_rst_mvld", int'(o_m_valid), 1);
         do_reset("rst_label");
         return;
      end
      label_pass(bp);
   endtask

   initial begin
      int lv[3];
      #1 i_rst_n = 1'b0;
      #1;
      check_eq("rst_srdy", int'(o_s_ready), 0);
      check_eq("rst_mvld", int'(o_m_valid), 0);
      check_eq("rst_busy", int'(o_busy), 0);
      check_eq("rst_done", int'(o_done), 0);
      check_eq("rst_pass", int'(o_pass_start), 0);
      check_eq("rst_iter", int'(o_iter_count), 0);
      repeat (3) @(negedge clk);
      i_rst_n = 1'b1;
      @(negedge clk);

      cur_frame = '{10, 10, 10, 10, 200, 200, 200, 200};
      run_job(0, 1'b0);
      cur_frame = '{100, 100, 100, 100, 100, 100, 100, 100};
      run_job(0, 1'b1);

      // Look for a frame that is still moving after ITERS passes so the cap is exercised.
      for (int t = 0; t < 500; t++) begin
         for (int x = 0; x < NPIX; x++) cur_frame[x] = int'($urandom_range(255));
         ref_model();
         if (exp_capped) break;
      end
      run_job(0, 1'b1);

      for (int t = 0; t < 8; t++) begin
         for (int l = 0; l < 3; l++) lv[l] = int'($urandom_range(255));
         for (int x = 0; x < NPIX; x++) begin
            if (t % 2 == 0) cur_frame[x] = int'($urandom_range(255));
            else begin
               cur_frame[x] = lv[$urandom_range(2)] + int'($urandom_range(6)) - 3;
               if (cur_frame[x] < 0) cur_frame[x] = 0;
               if (cur_frame[x] > 255) cur_frame[x] = 255;
            end
         end
         run_job(0, t[0]);
      end

      cur_frame = '{10, 10, 10, 10, 200, 200, 200, 200};
      run_job(1, 1'b0);
      run_job(2, 1'b0);
      run_job(0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/kmeans_stream_cluster.md
# kmeans_stream_cluster

Parametrised streaming k-means segmenter for greyscale frames. It accepts a pixel stream over a valid/ready handshake and refines K centroids over repeated passes of the same frame. Each pass uses exact per-cluster sums, counts and a serial divider, and the block exits early once the centroids stop changing. A final labelling pass emits each pixel's cluster index and centroid value. It sits between the frame source memory and the segmented-image writer, and replaces the fixed K=2 clusterer.

## Interface
- DATA_W, 8, pixel width in bits
- K, 4, number of clusters (K ≥ 2)
- NPIX, 900, pixels per frame (30×30)
- ITERS, 4, maximum refinement passes (≥ 1)
- LBL_W, $clog2(K), label width
- clk  in  1  the one clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a job; only honoured in IDLE
- s_valid / s_ready  in / out  1  input pixel handshake
- s_data  in  DATA_W  input pixel
- m_valid / m_ready  out / in  1  output handshake, LABEL pass only
- m_label  out  LBL_W  cluster index of the pixel
- m_data  out  DATA_W  centroid value of that cluster
- pass_start  out  1  one-cycle pulse on entry to ACCUM or LABEL; upstream restarts the frame from pixel 0
- iter_count  out  $clog2(ITERS+1)  number of completed refinement passes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes

## Operation
- States: IDLE → ACCUM → DIVIDE → (ACCUM | LABEL) → DONE → IDLE.
- Reset values: state IDLE; every output 0; centroid[i] = (i·(2^DATA_W−1))/(K−1), truncated; sums and counts 0.
- IDLE: on start, load the initial centroids, clear the accumulators, set iter_count=0, pulse pass_start and enter ACCUM. start is ignored in every other state.
- Nearest-centroid rule:
  - Distance is |pixel − centroid| on DATA_W+1 signed bits.
  - The minimum distance wins; on a tie the lowest index wins.
  - The rule is combinational and shared by ACCUM and LABEL.
- ACCUM:
  - s_ready=1.
  - Per handshake: sum[idx] += s_data and cnt[idx] += 1. sum is DATA_W+$clog2(NPIX+1) bits; cnt is $clog2(NPIX+1) bits; neither can overflow.
  - After the NPIX-th handshake, enter DIVIDE.
- DIVIDE:
  - s_ready=0.
  - Clusters are processed sequentially: 1 load cycle, then DATA_W restoring-division cycles per cluster. The quotient is truncated and fits in DATA_W.
  - If cnt==0, the centroid is kept unchanged, but the cluster still uses its full cycle slot.
  - A change flag is set if any new centroid differs from its old value.
  - At the end: iter_count += 1.
    - If change==0 or iter_count==ITERS: pulse pass_start and enter LABEL.
    - Otherwise: clear sums, counts and the flag, pulse pass_start and enter ACCUM.
- LABEL:
  - Uses a single output register.
  - s_ready = m_ready | ~m_valid.
  - On an input handshake, m_label and m_data load on the next edge and m_valid goes to 1.
  - m_valid drops once the register drains with no new input.
  - After NPIX output handshakes, enter DONE.
- DONE: done=1 for one cycle, then IDLE. Centroids are retained until the next start.

## Timing
- The ACCUM update is visible at the edge that completes the handshake. DIVIDE is entered on the edge of the last handshake.
- DIVIDE lasts exactly K·(DATA_W+1) cycles.
- LABEL latency is one cycle from input handshake to m_valid.
  - Full throughput when m_ready=1.
  - When m_valid=1 and m_ready=0, m_label and m_data are held stable and s_ready=0.
- s_valid with no handshake outside ACCUM/LABEL is ignored. No data is consumed and no state changes.
- Asynchronous reset at any point returns everything to reset values immediately. Any partial frame, division or output word is discarded. m_valid=0 is guaranteed from the reset assertion onward.
- pass_start and done never overlap. busy falls on the cycle after done.

## Test plan
- Convergence (K=2, NPIX=8, ITERS=4):
  - Stimulus: frame {10,10,10,10,200,200,200,200}.
  - Pass 0: centroids 0/255 → 10/200. Pass 1 produces no change, so LABEL is entered early.
  - Required: iter_count=2; outputs labels 0,0,0,0,1,1,1,1 with data 10,10,10,10,200,200,200,200; done pulses once.
- Empty cluster (K=4, NPIX=8):
  - Stimulus: eight pixels of value 100.
  - Required: centroids 0/85/170/255 → 0/100/170/255; every label=1 with data=100; iter_count=2.
- Tie and truncation (K=3, NPIX=4):
  - Initial centroids are 0/127/255.
  - Stimulus 191×4: tie between 127 and 255, so all pixels go to cluster 1 → centroid 191, labels all 1.
  - Stimulus {190,191,191,191}: centroid becomes 763/4 = 190, truncated.
- Iteration cap: ITERS=1 with the first frame → LABEL after one pass; iter_count=1; same labels.
- Backpressure:
  - Stimulus: m_ready pseudo-random at 50% and s_valid random during LABEL.
  - Required: exactly NPIX outputs in order, with no drops or duplicates, and m_data/m_label held while stalled.
- Reset mid-job:
  - Stimulus: drop rst after 3 ACCUM pixels.
  - Required: s_ready=0, busy=0, m_valid=0 immediately; a restarted job then reproduces the convergence result bit-exactly.
